alu_pipe_riscv: RTL and testbench

- Parametrised, registered successor to the 64-bit combinational RISC-V ALU.
- Handles integer ALU ops, branch compares and an iterative shift-add multiply.
- Uses valid/ready handshakes on input and output, with a tag carried alongside each operation.
- Sits between the issue stage and writeback of one superscalar lane; instantiated once per lane.

---
 rtl/alu_pipe_riscv.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe_riscv.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_riscv.sv
// Registered RISC-V lane ALU: single-cycle integer/branch ops plus an
// iterative shift-add multiply, with valid/ready handshakes and tags.
module alu_pipe_riscv #(
  parameter int XLEN   = 64,
  parameter int TAG_W  = 4,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_br_taken,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_BLT  = 4'h9;
  localparam logic [3:0] OP_BGE  = 4'hA;
  localparam logic [3:0] OP_SRA  = 4'hB;
  localparam logic [3:0] OP_SLT  = 4'hC;
  localparam logic [3:0] OP_SLTU = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;

  typedef enum logic {IDLE, MUL} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  acc_q, acc_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;

  logic             vld_q, vld_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             br_q, br_d;
  logic             ill_q, ill_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [XLEN-1:0]  alu_res;
  logic             alu_br;
  logic             alu_ill;
  logic [SH_W-1:0]  sh;
  logic             is_mul;
  logic             accept;
  logic             drain;

  assign sh     = op_b[SH_W-1:0];
  assign is_mul = (alu_op == OP_MUL) && (MUL_EN != 0);
  assign in_ready = !rst && (state_q == IDLE)
                    && (!vld_q || out_ready);
  assign accept = in_valid && in_ready;
  assign drain  = vld_q && out_ready;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    unique case (alu_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLL:  alu_res = op_a << sh;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SRL:  alu_res = op_a >> sh;
      OP_OR:   alu_res = op_a | op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_BEQ:  alu_br  = (op_a == op_b);
      OP_BNE:  alu_br  = (op_a != op_b);
      OP_BLT:  alu_br  = ($signed(op_a) < $signed(op_b));
      OP_BGE:  alu_br  = ($signed(op_a) >= $signed(op_b));
      OP_SRA:  alu_res = $signed(op_a) >>> sh;
      OP_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_res = XLEN'(op_a < op_b);
      OP_MUL:  alu_ill = (MUL_EN == 0);
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    mtag_d  = mtag_q;
    vld_d   = vld_q;
    res_d   = res_q;
    br_d    = br_q;
    ill_d   = ill_q;
    tag_d   = tag_q;
    // drain first; a same-cycle load below overrides it
    if (drain) begin
      vld_d = 1'b0;
      res_d = '0;
      br_d  = 1'b0;
      ill_d = 1'b0;
      tag_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d = MUL;
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          cnt_d   = '0;
          mtag_d  = in_tag;
        end else if (accept) begin
          vld_d = 1'b1;
          res_d = alu_res;
          br_d  = alu_br;
          ill_d = alu_ill;
          tag_d = in_tag;
        end
      end
      MUL: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          res_d   = acc_q;
          br_d    = 1'b0;
          ill_d   = 1'b0;
          tag_d   = mtag_q;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mtag_q  <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      mtag_q  <= mtag_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid    = vld_q;
  assign out_result   = res_q;
  assign out_br_taken = br_q;
  assign out_illegal  = ill_q;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_alu_pipe_riscv.sv
// Bench for alu_pipe_riscv: vector table, scoreboard monitor,
// multiply latency, backpressure, reset abort and MUL_EN=0 cases.
module tb_alu_pipe_riscv;
  localparam int XLEN  = 64;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic             out_br_taken;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  logic             nm_in_valid;
  logic             nm_in_ready;
  logic [3:0]       nm_alu_op;
  logic [XLEN-1:0]  nm_op_a;
  logic [XLEN-1:0]  nm_op_b;
  logic [TAG_W-1:0] nm_in_tag;
  logic             nm_out_valid;
  logic             nm_out_ready;
  logic [XLEN-1:0]  nm_out_result;
  logic             nm_out_br_taken;
  logic             nm_out_illegal;
  logic [TAG_W-1:0] nm_out_tag;

  always #5 clk = ~clk;

  alu_pipe_riscv #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_EN(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_br_taken(out_br_taken),
    .out_illegal(out_illegal), .out_tag(out_tag)
  );

  alu_pipe_riscv #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_EN(0)) u_nomul (
    .clk(clk), .rst(rst),
    .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .alu_op(nm_alu_op), .op_a(nm_op_a), .op_b(nm_op_b),
    .in_tag(nm_in_tag),
    .out_valid(nm_out_valid), .out_ready(nm_out_ready),
    .out_result(nm_out_result), .out_br_taken(nm_out_br_taken),
    .out_illegal(nm_out_illegal), .out_tag(nm_out_tag)
  );

  typedef struct {
    logic [3:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
    logic             br;
    logic             ill;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic             br;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: a result leaves at the next edge when valid & ready
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got tag %h res %h, expected none",
                 out_tag, out_result);
      end else begin
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if ({out_result, out_br_taken, out_illegal, out_tag} !==
            {e.res, e.br, e.ill, e.tag}) begin
          errors++;
          $display("FAIL result: got res %h br %b ill %b tag %h, expected res %h br %b ill %b tag %h",
                   out_result, out_br_taken, out_illegal, out_tag,
                   e.res, e.br, e.ill, e.tag);
        end
      end
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [XLEN-1:0] res, input logic br,
                      input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.res = res; v.br = br; v.ill = ill;
    vecs.push_back(v);
  endtask

  // called at posedge+2; returns at posedge+2 after the accepting edge
  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                      input logic [XLEN-1:0] res, input logic br,
                      input logic ill, input bit push);
    exp_t e;
    bit ok;
    ok = 1'b0;
    if (push) begin
      e.res = res; e.br = br; e.ill = ill; e.tag = tag;
      sb.push_back(e);
    end
    in_valid = 1'b1;
    alu_op = op; op_a = a; op_b = b; in_tag = tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready 0 for tag %h, expected 1", tag);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0",
               sb.size());
    end
  endtask

  initial begin
    int k;
    int n0;
    bit low_ok;
    bit quiet;
    bit ok;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; op_a = '0; op_b = '0; in_tag = '0;
    nm_in_valid = 1'b0; nm_out_ready = 1'b1;
    nm_alu_op = '0; nm_op_a = '0; nm_op_b = '0; nm_in_tag = '0;

    addv(4'h0, 64'd5, -64'd7, 4'h1, -64'd2, 1'b0, 1'b0);
    addv(4'h1, 64'd0, 64'd1, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    addv(4'h4, 64'h8000_0000_0000_0000, 64'h41, 4'h3,
         64'h4000_0000_0000_0000, 1'b0, 1'b0);
    addv(4'hB, 64'h8000_0000_0000_0000, 64'h41, 4'h4,
         64'hC000_0000_0000_0000, 1'b0, 1'b0);
    addv(4'h2, 64'h8000_0000_0000_0000, 64'h41, 4'h5, 64'd0, 1'b0, 1'b0);
    addv(4'h9, -64'd1, 64'd1, 4'h6, 64'd0, 1'b1, 1'b0);
    addv(4'hA, -64'd1, 64'd1, 4'h7, 64'd0, 1'b0, 1'b0);
    addv(4'h7, -64'd1, 64'd1, 4'h8, 64'd0, 1'b0, 1'b0);
    addv(4'h8, -64'd1, 64'd1, 4'h9, 64'd0, 1'b1, 1'b0);
    addv(4'hD, -64'd1, 64'd1, 4'hA, 64'd0, 1'b0, 1'b0);
    addv(4'hC, -64'd1, 64'd1, 4'hB, 64'd1, 1'b0, 1'b0);
    addv(4'h3, 64'hF0F0, 64'hFF00, 4'hC, 64'h0FF0, 1'b0, 1'b0);
    addv(4'h5, 64'hF0F0, 64'hFF00, 4'hD, 64'hFFF0, 1'b0, 1'b0);
    addv(4'h6, 64'hF0F0, 64'hFF00, 4'hE, 64'hF000, 1'b0, 1'b0);
    addv(4'h7, 64'd7, 64'd7, 4'hF, 64'd0, 1'b1, 1'b0);
    addv(4'hA, 64'd5, 64'd5, 4'h0, 64'd0, 1'b1, 1'b0);
    addv(4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'h1, 64'd0, 1'b0, 1'b0);
    addv(4'hF, 64'd3, 64'd4, 4'h2, 64'd0, 1'b0, 1'b1);
    addv(4'h2, 64'd1, 64'hFFC0_003F, 4'h3,
         64'h8000_0000_0000_0000, 1'b0, 1'b0);
    addv(4'hB, -64'd8, 64'h3F, 4'h4, -64'd1, 1'b0, 1'b0);
    addv(4'hD, 64'd1, -64'd1, 4'h5, 64'd1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_flags", 64'({out_br_taken, out_illegal}), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2;

    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
           vecs[i].res, vecs[i].br, vecs[i].ill, 1'b1);
    wait_empty();

    // MUL accepted on the edge the ADD result drains
    send(4'h0, 64'd3, 64'd4, 4'h1, 64'd7, 1'b0, 1'b0, 1'b1);
    send(4'hE, 64'd12345, -64'd3, 4'hA, -64'd37035, 1'b0, 1'b0, 1'b1);
    low_ok = 1'b1;
    k = 0;
    while (k < 80) begin
      @(negedge clk);
      if (out_valid) break;
      if (in_ready) low_ok = 1'b0;
      k++;
    end
    check("mul_latency", 64'(k), 64'd65);
    check("mul_in_ready_low", 64'(low_ok), 64'd1);
    @(posedge clk); #2;
    wait_empty();

    send(4'hE, -64'd1, -64'd1, 4'h6, 64'd1, 1'b0, 1'b0, 1'b1);
    wait_empty();

    nm_in_valid = 1'b1; nm_alu_op = 4'hE;
    nm_op_a = 64'd3; nm_op_b = 64'd4; nm_in_tag = 4'h3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (nm_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("nomul_accept", 64'(ok), 64'd1);
    @(posedge clk); #2;
    nm_in_valid = 1'b0;
    @(negedge clk);
    check("nomul_valid", 64'(nm_out_valid), 64'd1);
    check("nomul_illegal", 64'(nm_out_illegal), 64'd1);
    check("nomul_result", nm_out_result, 64'd0);
    check("nomul_tag", 64'(nm_out_tag), 64'd3);
    @(posedge clk); #2;

    out_ready = 1'b0;
    send(4'h0, 64'd10, 64'd20, 4'h1, 64'd30, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; alu_op = 4'h1;
    op_a = 64'd9; op_b = 64'd4; in_tag = 4'h2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", out_result, 64'd30);
      check("bp_tag", 64'({out_valid, out_tag}), 64'h11);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    n0 = pop_cyc.size();
    out_ready = 1'b1;
    send(4'h1, 64'd9, 64'd4, 4'h2, 64'd5, 1'b0, 1'b0, 1'b1);
    send(4'h3, 64'd6, 64'd3, 4'h3, 64'd5, 1'b0, 1'b0, 1'b1);
    wait_empty();
    if (pop_cyc.size() >= n0 + 3)
      check("bp_rate", 64'(pop_cyc[n0+2] - pop_cyc[n0]), 64'd2);
    else
      check("bp_pops", 64'(pop_cyc.size() - n0), 64'd3);

    send(4'hE, 64'd5, 64'd6, 4'h7, 64'd30, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mul_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check("rst_mul_no_out", 64'(quiet), 64'd1);
    @(posedge clk); #2;
    send(4'h0, 64'd1, 64'd1, 4'hC, 64'd2, 1'b0, 1'b0, 1'b1);
    wait_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
